// File: rtl/ft232_uart_rx.sv
// FTDI serial receive front end: pin synchronizer, 8N1 deserializer, 4-entry byte FIFO
// and sticky framing/overflow flags.
module ft232_uart_rx #(
    parameter int unsigned clk_per_bit = 100
) (
    input  logic       clk_lb,
    input  logic       rst_l,
    input  logic       ftdi_wi,
    input  logic       rx_pop,
    input  logic       err_clr,
    output logic [7:0] rx_d,
    output logic       rx_rdy,
    output logic       rx_busy,
    output logic       err_frame,
    output logic       err_ovf
);
    localparam logic [15:0] FullCnt = 16'(clk_per_bit - 1);
    localparam logic [15:0] HalfCnt = 16'(clk_per_bit / 2 - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e      state_q;
    logic [1:0]  sync_q;
    logic [15:0] bcnt_q;
    logic [2:0]  nbit_q;
    logic [7:0]  shift_q;
    logic        push_q;
    logic        err_frame_q;
    logic        rxs;
    logic        tick;

    assign rxs  = sync_q[1];
    assign tick = (bcnt_q == 16'd0);

    always_ff @(posedge clk_lb) begin
        if (!rst_l) begin
            state_q     <= StIdle;
            sync_q      <= 2'b11;
            bcnt_q      <= 16'd0;
            nbit_q      <= 3'd0;
            shift_q     <= 8'd0;
            push_q      <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], ftdi_wi};
            push_q <= 1'b0;
            if (err_clr) begin
                err_frame_q <= 1'b0;
            end
            if (state_q != StIdle && !tick) begin
                bcnt_q <= bcnt_q - 16'd1;
            end
            // Error set below overrides a coincident clear.
            case (state_q)
                StIdle: begin
                    if (!rxs) begin
                        bcnt_q  <= HalfCnt;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (tick) begin
                        if (rxs) begin
                            state_q <= StIdle;
                        end else begin
                            bcnt_q  <= FullCnt;
                            nbit_q  <= 3'd0;
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (tick) begin
                        shift_q[nbit_q] <= rxs;
                        bcnt_q          <= FullCnt;
                        nbit_q          <= nbit_q + 3'd1;
                        if (nbit_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end
                end
                StStop: begin
                    if (tick) begin
                        if (rxs) begin
                            push_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            err_frame_q <= 1'b1;
                            state_q     <= StBreak;
                        end
                    end
                end
                StBreak: begin
                    if (rxs) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic [7:0] mem_q [4];
    logic [1:0] wptr_q, rptr_q, rptr_d;
    logic [2:0] cnt_q, cnt_d;
    logic       full, do_pop, do_push;
    logic [7:0] head_d;
    logic [7:0] rx_d_q;
    logic       rx_rdy_q;
    logic       err_ovf_q;

    always_comb begin
        full    = (cnt_q == 3'd4);
        do_pop  = rx_pop && (cnt_q != 3'd0);
        do_push = push_q && (!full || do_pop);
        rptr_d  = do_pop ? rptr_q + 2'd1 : rptr_q;
        cnt_d   = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 3'd1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 3'd1;
        end
        // A byte written into the slot that becomes the head bypasses the array.
        head_d = (do_push && (wptr_q == rptr_d)) ? shift_q : mem_q[rptr_d];
    end

    always_ff @(posedge clk_lb) begin
        if (!rst_l) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 8'd0;
            end
            wptr_q    <= 2'd0;
            rptr_q    <= 2'd0;
            cnt_q     <= 3'd0;
            rx_d_q    <= 8'd0;
            rx_rdy_q  <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= shift_q;
                wptr_q        <= wptr_q + 2'd1;
            end
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            rx_d_q   <= head_d;
            rx_rdy_q <= (cnt_d != 3'd0);
            if (err_clr) begin
                err_ovf_q <= 1'b0;
            end
            if (push_q && full && !do_pop) begin
                err_ovf_q <= 1'b1;
            end
        end
    end

    assign rx_d      = rx_d_q;
    assign rx_rdy    = rx_rdy_q;
    assign rx_busy   = (state_q != StIdle);
    assign err_frame = err_frame_q;
    assign err_ovf   = err_ovf_q;
endmodule

// File: tb/tb_ft232_uart_rx.sv
// Directed bench for ft232_uart_rx: drives 8N1 frames cycle by cycle and checks the FIFO
// contents against a byte queue model.
module tb_ft232_uart_rx;
    localparam int C        = 16;
    localparam int H        = C / 2;
    localparam int PopAt    = 3 + H + 9 * C;
    localparam int RdyEdge  = 4 + H + 9 * C;

    logic       clk_lb = 1'b0;
    logic       rst_l;
    logic       ftdi_wi;
    logic       rx_pop;
    logic       err_clr;
    logic [7:0] rx_d;
    logic       rx_rdy;
    logic       rx_busy;
    logic       err_frame;
    logic       err_ovf;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] sb [$];
    logic       exp_ovf = 1'b0;

    ft232_uart_rx #(.clk_per_bit(C)) dut (
        .clk_lb   (clk_lb),
        .rst_l    (rst_l),
        .ftdi_wi  (ftdi_wi),
        .rx_pop   (rx_pop),
        .err_clr  (err_clr),
        .rx_d     (rx_d),
        .rx_rdy   (rx_rdy),
        .rx_busy  (rx_busy),
        .err_frame(err_frame),
        .err_ovf  (err_ovf)
    );

    always #5 clk_lb = ~clk_lb;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_lb);
            #1;
        end
    endtask

    // One 8N1 frame; pop_at/rst_at < 0 disable the pop/reset pulse at that frame cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_at,
                              input int rst_at, input bit chk);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int c = 0; c < 10 * C; c++) begin
            ftdi_wi = bits[c / C];
            rx_pop  = (c == pop_at);
            rst_l   = !(c == rst_at);
            if (c == pop_at) begin
                check("simpop_rdy", {7'd0, rx_rdy}, 8'd1);
                check("simpop_head", rx_d, sb[0]);
            end
            step(1);
            if (chk) begin
                if (c + 1 == 5)           check("busy_in_frame", {7'd0, rx_busy}, 8'd1);
                if (c + 1 == RdyEdge - 1) check("rdy_early", {7'd0, rx_rdy}, 8'd0);
                if (c + 1 == RdyEdge) begin
                    check("rdy_latency", {7'd0, rx_rdy}, 8'd1);
                    check("rdy_data", rx_d, b);
                end
            end
        end
        rx_pop = 1'b0;
        rst_l  = 1'b1;
        if (rst_at >= 0) begin
            sb.delete();
        end else if (stop) begin
            if (pop_at >= 0) begin
                void'(sb.pop_front());
                sb.push_back(b);
            end else if (sb.size() < 4) begin
                sb.push_back(b);
            end else begin
                exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            check("drain_rdy", {7'd0, rx_rdy}, 8'd1);
            check("drain_data", rx_d, sb.pop_front());
            rx_pop = 1'b1;
            step(1);
            rx_pop = 1'b0;
        end
        check("drain_empty", {7'd0, rx_rdy}, 8'd0);
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        exp_ovf = 1'b0;
        check("clr_frame", {7'd0, err_frame}, 8'd0);
        check("clr_ovf", {7'd0, err_ovf}, 8'd0);
    endtask

    initial begin
        rst_l   = 1'b0;
        ftdi_wi = 1'b1;
        rx_pop  = 1'b0;
        err_clr = 1'b0;
        step(3);
        check("rst_rdy", {7'd0, rx_rdy}, 8'd0);
        check("rst_d", rx_d, 8'h00);
        check("rst_busy", {7'd0, rx_busy}, 8'd0);
        check("rst_frame", {7'd0, err_frame}, 8'd0);
        check("rst_ovf", {7'd0, err_ovf}, 8'd0);
        rst_l = 1'b1;
        step(4);

        // Single byte with exact latency
        send_frame(8'h5A, 1'b1, -1, -1, 1'b1);
        check("idle_after", {7'd0, rx_busy}, 8'd0);
        drain();

        // Glitch rejection
        ftdi_wi = 1'b0;
        step(5);
        ftdi_wi = 1'b1;
        step(1);
        check("glitch_busy", {7'd0, rx_busy}, 8'd1);
        step(20);
        check("glitch_idle", {7'd0, rx_busy}, 8'd0);
        check("glitch_rdy", {7'd0, rx_rdy}, 8'd0);
        check("glitch_frame", {7'd0, err_frame}, 8'd0);

        // Framing error followed by a held-low break
        send_frame(8'hC3, 1'b0, -1, -1, 1'b0);
        ftdi_wi = 1'b0;
        step(3 * C);
        check("brk_frame", {7'd0, err_frame}, 8'd1);
        check("brk_busy", {7'd0, rx_busy}, 8'd1);
        check("brk_rdy", {7'd0, rx_rdy}, 8'd0);
        ftdi_wi = 1'b1;
        step(5);
        check("brk_release", {7'd0, rx_busy}, 8'd0);
        send_frame(8'h11, 1'b1, -1, -1, 1'b0);
        drain();
        clear_errors();

        // Overflow
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, -1, -1, 1'b0);
        end
        check("ovf_flag", {7'd0, err_ovf}, {7'd0, exp_ovf});
        drain();
        clear_errors();

        // Full FIFO with pop on the push cycle
        for (int i = 0; i < 4; i++) begin
            send_frame(8'h10 + 8'(i), 1'b1, -1, -1, 1'b0);
        end
        send_frame(8'h14, 1'b1, PopAt, -1, 1'b0);
        check("simpop_ovf", {7'd0, err_ovf}, 8'd0);
        drain();

        // Reset in data bit 3, with a byte left in the FIFO
        send_frame(8'h3C, 1'b1, -1, -1, 1'b0);
        send_frame(8'hFF, 1'b1, -1, 4 * C + 6, 1'b0);
        check("mrst_rdy", {7'd0, rx_rdy}, 8'd0);
        check("mrst_d", rx_d, 8'h00);
        check("mrst_busy", {7'd0, rx_busy}, 8'd0);
        check("mrst_frame", {7'd0, err_frame}, 8'd0);
        check("mrst_ovf", {7'd0, err_ovf}, 8'd0);
        send_frame(8'hA5, 1'b1, -1, -1, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
